// File: rtl/syn_cnt_pkg.sv
// rtl/syn_cnt_pkg.sv - shared constants for the JK up/down counter family
//
// Purpose: direction encodings and the J/K pair encodings used by the counter
//          next-state decode and by the jk_cell storage element.
// Contents:
//   CNT_UP / CNT_DOWN          value of the up input for each direction
//   JK_HOLD/JK_CLR/JK_SET/JK_TGL  {j,k} pairs: hold, clear, set, toggle
package syn_cnt_pkg;

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/syn_updown_jk_counter_if.sv
// rtl/syn_updown_jk_counter_if.sv - control/status bundle of the JK up/down counter
//
// Purpose: groups the counter control inputs and status outputs.
// Signals:
//   en     count enable (one step per cycle)
//   up     direction, 1 = up, 0 = down
//   load   parallel load strobe
//   din    parallel load value [WIDTH-1:0]
//   count  registered count [WIDTH-1:0]
//   tc     combinational terminal count / cascade carry
//   wrap   registered one-cycle pulse after a wrap-around
// Modports: master drives controls, slave is the counter itself.
interface syn_updown_jk_counter_if #(
    parameter int WIDTH = 4
);

    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, din,
        input  count, tc, wrap
    );

    modport slave (
        input  en, up, load, din,
        output count, tc, wrap
    );

endinterface

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - one-bit JK storage cell with synchronous active-low reset
//
// Purpose: single counter bit; {j,k} = 00 hold, 01 clear, 10 set, 11 toggle.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset, q resets to 0
//   j,k  JK control pair
//   q    cell output
//   qb   inverted cell output
module jk_cell
    import syn_cnt_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= 1'b0;
        end else begin
            case ({j, k})
                JK_SET:  q_q <= 1'b1;
                JK_CLR:  q_q <= 1'b0;
                JK_TGL:  q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q  = q_q;
    assign qb = ~q_q;

endmodule

// File: rtl/syn_updown_jk_counter.sv
// rtl/syn_updown_jk_counter.sv - modulo-N synchronous up/down counter of JK cells
//
// Purpose: WIDTH-bit modulo-MODULUS counter with enable, direction, parallel
//          load (clamped to MODULUS-1), cascade terminal count and wrap pulse.
// Parameters: WIDTH (2..16), MODULUS (2..2**WIDTH)
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  slave side of syn_updown_jk_counter_if (en/up/load/din in,
//        count/tc/wrap out)
module syn_updown_jk_counter
    import syn_cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    syn_updown_jk_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_b;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] wrap_val;
    logic             at_max;
    logic             at_zero;
    logic             tc;
    logic             wrap_q;

    assign at_max  = (count_q == MAX_C);
    assign at_zero = &count_b;

    // tc marks the exact cycle whose edge will wrap; it doubles as the
    // ripple enable for the next cascaded stage.
    assign tc = bus.en & (((bus.up == CNT_UP) & at_max) |
                          ((bus.up == CNT_DOWN) & at_zero));

    // Compare one bit wider so the clamp is well-formed when MODULUS = 2**WIDTH.
    assign load_val = ({1'b0, bus.din} >= MOD_W) ? MAX_C : bus.din;
    assign wrap_val = (bus.up == CNT_UP) ? '0 : MAX_C;

    always_comb begin
        t_up    = '0;
        t_dn    = '0;
        j_d     = '0;
        k_d     = '0;
        t_up[0] = 1'b1;
        t_dn[0] = 1'b1;
        // Bit i toggles when all lower bits are 1 (up) or all are 0 (down).
        for (int i = 1; i < WIDTH; i++) begin
            t_up[i] = t_up[i-1] & count_q[i-1];
            t_dn[i] = t_dn[i-1] & count_b[i-1];
        end
        if (bus.load) begin
            j_d = load_val;
            k_d = ~load_val;
        end else if (tc) begin
            // Modulo wrap forces the target value with set/clear encoding.
            j_d = wrap_val;
            k_d = ~wrap_val;
        end else if (bus.en) begin
            j_d = (bus.up == CNT_UP) ? t_up : t_dn;
            k_d = (bus.up == CNT_UP) ? t_up : t_dn;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j_d[g]),
            .k   (k_d[g]),
            .q   (count_q[g]),
            .qb  (count_b[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrap_q <= 1'b0;
        end else if (bus.load) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= tc;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc;
    assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_syn_updown_jk_counter.sv
// tb/tb_syn_updown_jk_counter.sv - self-checking bench for syn_updown_jk_counter
module tb_syn_updown_jk_counter;

    localparam int MA = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_c = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   m_cnt = 0;
    logic m_wrap = 1'b0;
    int   wraps = 0;

    always #5 clk = ~clk;

    syn_updown_jk_counter_if #(.WIDTH(4)) ba ();
    syn_updown_jk_counter_if #(.WIDTH(4)) c0 ();
    syn_updown_jk_counter_if #(.WIDTH(4)) c1 ();

    assign c1.en = c0.tc;

    syn_updown_jk_counter #(.WIDTH(4), .MODULUS(MA)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ba.slave)
    );

    syn_updown_jk_counter #(.WIDTH(4), .MODULUS(16)) dut_c0 (
        .clk (clk),
        .rst (rst_c),
        .bus (c0.slave)
    );

    syn_updown_jk_counter #(.WIDTH(4), .MODULUS(16)) dut_c1 (
        .clk (clk),
        .rst (rst_c),
        .bus (c1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clocked step on dut_a: drive, check tc before the edge, then update
    // the reference model and check the registered outputs after the edge.
    task automatic step(input logic r, input logic l, input logic e,
                        input logic u, input logic [3:0] d);
        logic exp_tc;
        rst     = r;
        ba.load = l;
        ba.en   = e;
        ba.up   = u;
        ba.din  = d;
        #1;
        exp_tc = e && (u ? (m_cnt == MA - 1) : (m_cnt == 0));
        chk("tc", 32'(ba.tc), 32'(exp_tc));
        @(posedge clk);
        if (!r) begin
            m_cnt  = 0;
            m_wrap = 1'b0;
        end else if (l) begin
            m_cnt  = (int'(d) < MA) ? int'(d) : MA - 1;
            m_wrap = 1'b0;
        end else if (e) begin
            if (u) begin
                m_wrap = (m_cnt == MA - 1);
                m_cnt  = (m_cnt + 1) % MA;
            end else begin
                m_wrap = (m_cnt == 0);
                m_cnt  = (m_cnt + MA - 1) % MA;
            end
        end else begin
            m_wrap = 1'b0;
        end
        #1;
        chk("count", 32'(ba.count), 32'(m_cnt));
        chk("wrap", 32'(ba.wrap), 32'(m_wrap));
    endtask

    initial begin
        ba.load = 1'b1;
        ba.en   = 1'b1;
        ba.up   = 1'b1;
        ba.din  = 4'd7;
        c0.en   = 1'b1;
        c0.up   = 1'b1;
        c0.load = 1'b0;
        c0.din  = '0;
        c1.up   = 1'b1;
        c1.load = 1'b0;
        c1.din  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(ba.count), 32'd0);
        chk("rst_wrap", 32'(ba.wrap), 32'd0);

        // Reset priority over load/en mid-count, then count resumes 1,2,3
        step(1, 1, 0, 0, 4'd7);
        step(0, 1, 1, 1, 4'd3);
        repeat (3) step(1, 0, 1, 1, 4'd0);

        // Up wrap from 0 through 9 and back to 0
        step(1, 1, 0, 1, 4'd0);
        repeat (11) step(1, 0, 1, 1, 4'd0);

        // Down wrap: 2 -> 1,0,9,8
        step(1, 1, 0, 0, 4'd2);
        repeat (4) step(1, 0, 1, 0, 4'd0);

        // Load priority and clamp
        step(1, 1, 1, 1, 4'd5);
        step(1, 1, 1, 0, 4'd13);
        step(1, 1, 1, 1, 4'd15);

        // Hold then direction flips
        step(1, 1, 0, 1, 4'd4);
        repeat (3) step(1, 0, 0, 1, 4'd0);
        step(1, 0, 1, 1, 4'd0);
        step(1, 0, 1, 0, 4'd0);
        step(1, 0, 1, 1, 4'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom),
                 4'($urandom_range(0, 15)));
        end

        // Full-range cascade of two MODULUS=16 stages
        rst_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("casc_rst", 32'({c1.count, c0.count}), 32'd0);
        rst_c = 1'b1;
        for (int i = 1; i <= 257; i++) begin
            @(posedge clk);
            #1;
            chk("casc_value", 32'({c1.count, c0.count}), 32'(i % 256));
            chk("casc_wrap1", 32'(c1.wrap), 32'(i == 256));
            if (c1.wrap === 1'b1) wraps++;
        end
        chk("casc_wrap_count", 32'(wraps), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
